// File: rtl/nox_boot_seq.sv
// Boot/reset sequencer: qualifies clock lock, then releases memories, core reset and fetch in order.
// Optional watchdog reboot is compiled in with `define BOOT_WDT_EN.
module nox_boot_seq #(
  parameter int          LOCK_STABLE_CYCLES = 256,
  parameter int          RST_HOLD_CYCLES    = 16,
  parameter logic [31:0] BOOT_ADDR          = 32'h8000_0000,
  parameter int          WDT_CYCLES         = 2**20
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        locked_i,
  input  logic        sw_rst_req_i,
  input  logic [31:0] sw_boot_addr_i,
  input  logic        wdt_kick_i,
  output logic        mem_rst_no,
  output logic        core_arst_no,
  output logic        start_fetch_o,
  output logic [31:0] start_addr_o,
  output logic [2:0]  boot_state_o,
  output logic [7:0]  boot_cnt_o,
  output logic        wdt_expired_o
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam int SEQ_MAX = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                  : RST_HOLD_CYCLES;
`ifdef BOOT_WDT_EN
  localparam int CNT_MAX = (WDT_CYCLES > SEQ_MAX) ? WDT_CYCLES : SEQ_MAX;
`else
  localparam int CNT_MAX = SEQ_MAX;
`endif
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lock_sync;
  logic             lock_s;
  logic             wdt_fire;
  logic             reboot;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) lock_sync <= 2'b00;
    else       lock_sync <= {lock_sync[0], locked_i};
  end
  assign lock_s = lock_sync[1];

  // Any combination of lock loss, watchdog and software request in RUN is a single reboot.
  assign reboot = (state == S_RUN) && (!lock_s || wdt_fire || sw_rst_req_i);

  // NOTE: next_state gets a default before the case so the comb block cannot infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_RESET:     next_state = S_WAIT_LOCK;
      S_WAIT_LOCK: if (lock_s) next_state = S_STABLE;
      S_STABLE: begin
        if (!lock_s)                 next_state = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST) next_state = S_HOLD;
      end
      S_HOLD: begin
        if (!lock_s)               next_state = S_WAIT_LOCK;
        else if (cnt == HOLD_LAST) next_state = S_RUN;
      end
      S_RUN:       if (reboot) next_state = S_WAIT_LOCK;
      default:     next_state = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state         <= S_RESET;
      cnt           <= '0;
      mem_rst_no    <= 1'b0;
      core_arst_no  <= 1'b0;
      start_fetch_o <= 1'b0;
      start_addr_o  <= BOOT_ADDR;
      boot_cnt_o    <= 8'd0;
    end else begin
      state <= next_state;
      if (next_state != state)
        cnt <= '0;
      else if (state == S_STABLE || state == S_HOLD)
        cnt <= cnt + 1'b1;
      // Outputs decode the next state so they change on the same edge as the state.
      mem_rst_no    <= (next_state == S_HOLD) || (next_state == S_RUN);
      core_arst_no  <= (next_state == S_RUN);
      start_fetch_o <= (next_state == S_RUN) && (state == S_RUN);
      if (reboot && boot_cnt_o != 8'hff)
        boot_cnt_o <= boot_cnt_o + 8'd1;
      if (state == S_RUN && sw_rst_req_i)
        start_addr_o <= sw_boot_addr_i;
    end
  end

  assign boot_state_o = state;

`ifdef BOOT_WDT_EN
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);
  logic [CNT_W-1:0] wdt_cnt;

  // A kick in the expiry cycle wins and restarts the count.
  assign wdt_fire = (state == S_RUN) && !wdt_kick_i && (wdt_cnt == WDT_LAST);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wdt_cnt       <= '0;
      wdt_expired_o <= 1'b0;
    end else begin
      if (state == S_RUN && next_state == S_RUN)
        wdt_cnt <= wdt_kick_i ? '0 : wdt_cnt + 1'b1;
      else
        wdt_cnt <= '0;
      if (wdt_fire)
        wdt_expired_o <= 1'b1;
    end
  end
`else
  localparam int unused_wdt_cycles = WDT_CYCLES;
  logic unused_kick;
  assign unused_kick   = wdt_kick_i;
  assign wdt_fire      = 1'b0;
  assign wdt_expired_o = 1'b0;
`endif

endmodule

// File: tb/tb_nox_boot_seq.sv
// Scoreboard bench for nox_boot_seq: stimulus queues expected output changes, a monitor pops them.
// Build with BOOT_WDT_EN defined to exercise the watchdog section.
module tb_nox_boot_seq;
  localparam int          LSC  = 4;
  localparam int          RHC  = 2;
  localparam int          WDT  = 8;
  localparam logic [31:0] BOOT = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        arst;
  logic        locked_i;
  logic        sw_rst_req_i;
  logic [31:0] sw_boot_addr_i;
  logic        wdt_kick_i;
  logic        mem_rst_no;
  logic        core_arst_no;
  logic        start_fetch_o;
  logic [31:0] start_addr_o;
  logic [2:0]  boot_state_o;
  logic [7:0]  boot_cnt_o;
  logic        wdt_expired_o;

  nox_boot_seq #(
    .LOCK_STABLE_CYCLES(LSC),
    .RST_HOLD_CYCLES   (RHC),
    .BOOT_ADDR         (BOOT),
    .WDT_CYCLES        (WDT)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .locked_i      (locked_i),
    .sw_rst_req_i  (sw_rst_req_i),
    .sw_boot_addr_i(sw_boot_addr_i),
    .wdt_kick_i    (wdt_kick_i),
    .mem_rst_no    (mem_rst_no),
    .core_arst_no  (core_arst_no),
    .start_fetch_o (start_fetch_o),
    .start_addr_o  (start_addr_o),
    .boot_state_o  (boot_state_o),
    .boot_cnt_o    (boot_cnt_o),
    .wdt_expired_o (wdt_expired_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          edge_n;
    logic [2:0]  st;
    logic        mem;
    logic        core;
    logic        fetch;
    logic [31:0] addr;
    logic [7:0]  cnt;
    logic        wdt;
  } exp_t;

  exp_t sb[$];
  bit   mon_en  = 1'b0;
  logic exp_wdt = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int e, input logic [2:0] st, input logic mem, input logic core,
                      input logic fetch, input logic [31:0] addr, input logic [7:0] cnt);
    exp_t x;
    x.edge_n = e; x.st = st; x.mem = mem; x.core = core; x.fetch = fetch;
    x.addr = addr; x.cnt = cnt; x.wdt = exp_wdt;
    sb.push_back(x);
  endtask

  // Edge 0 is the first edge with locked_i high; state changes follow at fixed offsets.
  task automatic push_boot(input int base, input logic [31:0] addr, input logic [7:0] cnt);
    push(base + 2,             3'd2, 1'b0, 1'b0, 1'b0, addr, cnt);
    push(base + 2 + LSC,       3'd3, 1'b1, 1'b0, 1'b0, addr, cnt);
    push(base + 2 + LSC + RHC, 3'd4, 1'b1, 1'b1, 1'b0, addr, cnt);
    push(base + 3 + LSC + RHC, 3'd4, 1'b1, 1'b1, 1'b1, addr, cnt);
  endtask

  function automatic logic [46:0] snap();
    return {boot_state_o, mem_rst_no, core_arst_no, start_fetch_o,
            start_addr_o, boot_cnt_o, wdt_expired_o};
  endfunction

  // Monitor: any change of the output bundle must match the head of the scoreboard.
  initial begin
    logic [46:0] prev;
    logic [46:0] cur;
    exp_t        x;
    @(posedge clk);
    #2 prev = snap();
    forever begin
      @(posedge clk);
      #2 cur = snap();
      if (mon_en && cur !== prev) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_change edge=%0d actual_state=%0d cnt=%0d wdt=%0b required=no_change",
                   cyc, boot_state_o, boot_cnt_o, wdt_expired_o);
        end else begin
          x = sb.pop_front();
          check("edge",  cyc,           x.edge_n);
          check("state", boot_state_o,  x.st);
          check("mem",   mem_rst_no,    x.mem);
          check("core",  core_arst_no,  x.core);
          check("fetch", start_fetch_o, x.fetch);
          check("addr",  start_addr_o,  x.addr);
          check("cnt",   boot_cnt_o,    x.cnt);
          check("wdt",   wdt_expired_o, x.wdt);
        end
      end
      prev = cur;
    end
  end

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual_pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  // Drop lock in RUN (optionally with a simultaneous software request), then relock.
  task automatic lock_loss_reboot(input logic with_sw, input logic [31:0] addr, input logic [7:0] cnt);
    int n;
    int base;
    n = cyc;
    locked_i = 1'b0;
    push(n + 3, 3'd1, 1'b0, 1'b0, 1'b0, addr, cnt);
    if (with_sw) begin
      to_cyc(n + 2);
      sw_rst_req_i   = 1'b1;
      sw_boot_addr_i = addr;
      @(negedge clk);
      sw_rst_req_i   = 1'b0;
    end
    to_cyc(n + 6);
    locked_i = 1'b1;
    base = cyc + 1;
    push_boot(base, addr, cnt);
    drain(40);
  endtask

  initial begin
    int          base;
    int          k;
    int          last_kick;
    logic [7:0]  bc;
    arst = 1'b0; locked_i = 1'b0; sw_rst_req_i = 1'b0;
    sw_boot_addr_i = 32'h0; wdt_kick_i = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_state", boot_state_o,  3'd0);
    check("rst_mem",   mem_rst_no,    1'b0);
    check("rst_core",  core_arst_no,  1'b0);
    check("rst_fetch", start_fetch_o, 1'b0);
    check("rst_addr",  start_addr_o,  BOOT);
    check("rst_cnt",   boot_cnt_o,    8'd0);
    check("rst_wdt",   wdt_expired_o, 1'b0);

    mon_en = 1'b1;
    arst   = 1'b1;
    push(cyc + 1, 3'd1, 1'b0, 1'b0, 1'b0, BOOT, 8'd0);
    drain(10);

    // Lock glitch in STABLE: back to WAIT_LOCK, full stable period restarts.
    locked_i = 1'b1;
    base = cyc + 1;
    push(base + 2, 3'd2, 1'b0, 1'b0, 1'b0, BOOT, 8'd0);
    to_cyc(base + 2);
    locked_i = 1'b0;
    push(base + 5, 3'd1, 1'b0, 1'b0, 1'b0, BOOT, 8'd0);
    @(negedge clk);
    locked_i = 1'b1;
    push_boot(cyc + 1, BOOT, 8'd0);
    drain(40);

    // Software reboot with a new boot address.
    sw_rst_req_i   = 1'b1;
    sw_boot_addr_i = 32'h8000_1000;
    k = cyc + 1;
    push(k, 3'd1, 1'b0, 1'b0, 1'b0, 32'h8000_1000, 8'd1);
    push_boot(k - 1, 32'h8000_1000, 8'd1);
    @(negedge clk);
    sw_rst_req_i   = 1'b0;
    sw_boot_addr_i = 32'h0;
    drain(40);

    // Lock-loss reboot keeps the address.
    lock_loss_reboot(1'b0, 32'h8000_1000, 8'd2);
    // Lock loss and software request on the same edge count once.
    lock_loss_reboot(1'b1, 32'h8000_2000, 8'd3);
    bc = 8'd3;

`ifdef BOOT_WDT_EN
    last_kick = 0;
    for (int i = 0; i < 6; i++) begin
      wdt_kick_i = 1'b1;
      last_kick  = cyc + 1;
      @(negedge clk);
      wdt_kick_i = 1'b0;
      repeat (4) @(negedge clk);
    end
    bc = bc + 8'd1;
    exp_wdt = 1'b1;
    push(last_kick + WDT, 3'd1, 1'b0, 1'b0, 1'b0, 32'h8000_2000, bc);
    push_boot(last_kick + WDT - 1, 32'h8000_2000, bc);
    drain(60);
`else
    last_kick = 0;
    for (int i = 0; i < 3; i++) begin
      wdt_kick_i = 1'b1;
      last_kick  = cyc + 1;
      @(negedge clk);
      wdt_kick_i = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("nowdt_state", boot_state_o,  3'd4);
    check("nowdt_flag",  wdt_expired_o, 1'b0);
`endif

    // Software reboot, then assert arst in the middle of HOLD.
    sw_rst_req_i   = 1'b1;
    sw_boot_addr_i = 32'h8000_3000;
    k = cyc + 1;
    bc = bc + 8'd1;
    push(k,           3'd1, 1'b0, 1'b0, 1'b0, 32'h8000_3000, bc);
    push(k + 1,       3'd2, 1'b0, 1'b0, 1'b0, 32'h8000_3000, bc);
    push(k + 1 + LSC, 3'd3, 1'b1, 1'b0, 1'b0, 32'h8000_3000, bc);
    @(negedge clk);
    sw_rst_req_i = 1'b0;
    to_cyc(k + 2 + LSC);
    drain(5);
    check("hold_mem", mem_rst_no, 1'b1);
    mon_en   = 1'b0;
    locked_i = 1'b0;
    arst     = 1'b0;
    #1;
    check("arst_state", boot_state_o,  3'd0);
    check("arst_mem",   mem_rst_no,    1'b0);
    check("arst_core",  core_arst_no,  1'b0);
    check("arst_fetch", start_fetch_o, 1'b0);
    check("arst_addr",  start_addr_o,  BOOT);
    check("arst_cnt",   boot_cnt_o,    8'd0);
    check("arst_wdt",   wdt_expired_o, 1'b0);
    exp_wdt = 1'b0;

    // Fresh boot: mem release at edge 6, core at 8, fetch at 9.
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    arst   = 1'b1;
    push(cyc + 1, 3'd1, 1'b0, 1'b0, 1'b0, BOOT, 8'd0);
    drain(10);
    locked_i = 1'b1;
    push_boot(cyc + 1, BOOT, 8'd0);
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nox_boot_seq.md
# nox_boot_seq

Boot/reset sequencer between the clock generator's LOCKED output and the nox core plus its instruction/data AXI memories. It synchronizes the asynchronous lock indication, qualifies lock stability, then releases memories, core reset and fetch in a fixed order. It re-sequences the system on lock loss, on a software reboot request that can carry a new boot address, and optionally on watchdog expiry.

## Interface
- LOCK_STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before leaving lock qualification (≥2).
- RST_HOLD_CYCLES, 16: cycles the memories run out of reset before core reset release (≥1).
- BOOT_ADDR, 32'h8000_0000: start address after `arst`.
- WDT_CYCLES, 2**20: watchdog timeout in cycles (≥2; used only with BOOT_WDT_EN).

Ports:
- clk  in  1  system clock.
- arst  in  1  asynchronous reset, active-low.
- locked_i  in  1  clock generator lock; asynchronous to clk.
- sw_rst_req_i  in  1  one-cycle software reboot request.
- sw_boot_addr_i  in  32  boot address captured with an accepted sw_rst_req_i.
- wdt_kick_i  in  1  watchdog restart pulse.
- mem_rst_no  out  1  memory reset, active-low.
- core_arst_no  out  1  core reset, active-low.
- start_fetch_o  out  1  fetch enable to core.
- start_addr_o  out  32  core start address.
- boot_state_o  out  3  current FSM state encoding.
- boot_cnt_o  out  8  reboots since `arst`, saturating at 255.
- wdt_expired_o  out  1  sticky watchdog-expiry flag.

## Operation
- locked_i passes through a 2-flop synchronizer (reset 0) → lock_s. Only lock_s is used internally.
- States, encoding in parentheses: RESET(0), WAIT_LOCK(1), STABLE(2), HOLD(3), RUN(4).
- RESET → WAIT_LOCK on the first edge after `arst` deasserts.
- WAIT_LOCK → STABLE when lock_s=1. Entering STABLE clears the counter.
- STABLE:
  - lock_s=0 → WAIT_LOCK.
  - Otherwise the counter increments. At cnt==LOCK_STABLE_CYCLES-1 → HOLD, and the counter clears.
- HOLD:
  - lock_s=0 → WAIT_LOCK.
  - At cnt==RST_HOLD_CYCLES-1 → RUN.
- RUN: a reboot event → WAIT_LOCK. Reboot events are lock_s=0, watchdog expiry, or sw_rst_req_i=1.
  - Several events in the same cycle count as one reboot.
  - boot_cnt_o increments once per reboot, saturating at 255.
- sw_rst_req_i is ignored outside RUN.
- sw_boot_addr_i is captured into start_addr_o only when a software request is accepted in RUN.
- Lock-loss and watchdog reboots keep the current start_addr_o.
- Outputs are registered and decoded from the next state:
  - mem_rst_no=1 in HOLD and RUN.
  - core_arst_no=1 in RUN.
  - start_fetch_o=1 in RUN, except on the first RUN cycle.
- Counter width is $clog2 of the largest parameter in use.

## Timing
- Reset values while `arst`=0:
  - state RESET.
  - mem_rst_no=0, core_arst_no=0, start_fetch_o=0.
  - start_addr_o=BOOT_ADDR, boot_cnt_o=0, wdt_expired_o=0, counters 0.
- Edge numbering: locked_i is high before edge 0, with FSM in WAIT_LOCK.
  - lock_s=1 after edge 1.
  - STABLE after edge 2.
  - mem_rst_no=1 after edge 2+LOCK_STABLE_CYCLES.
  - core_arst_no=1 after edge 2+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES.
  - start_fetch_o=1 one edge later.
  - With default parameters these are edges 258, 274 and 275.
- Reboot in RUN sampled at edge k:
  - After edge k, state is WAIT_LOCK and all three control outputs are 0.
  - boot_cnt_o is incremented and start_addr_o updated, if applicable.
- Lock loss reaches the FSM 2 edges after locked_i falls.
- `arst` assertion at any point drives all outputs to reset values immediately (asynchronous).

## Configuration
- BOOT_WDT_EN defined:
  - In RUN, the watchdog counter increments every cycle.
  - wdt_kick_i clears the counter; a kick takes priority over expiry in the same cycle.
  - The counter also clears when leaving RUN.
  - At WDT_CYCLES-1 the watchdog expires: reboot, and wdt_expired_o is set (cleared only by `arst`).
- BOOT_WDT_EN undefined: no watchdog logic, wdt_kick_i ignored, wdt_expired_o tied 0.

## Test plan
- LOCK_STABLE_CYCLES=4, RST_HOLD_CYCLES=2; raise locked_i before edge 0 → mem_rst_no=1 after edge 6, core_arst_no=1 after edge 8, start_fetch_o=1 after edge 9, boot_state_o=4.
- Lock glitch: drop locked_i for 1 cycle during STABLE → return to WAIT_LOCK; counter restarts, release delayed by the full stable period; boot_cnt_o stays 0.
- In RUN, pulse sw_rst_req_i with sw_boot_addr_i=32'h8000_1000 → control outputs low next edge, full sequence repeats, start_addr_o=32'h8000_1000, boot_cnt_o=1. A second reboot via lock loss keeps 32'h8000_1000 with boot_cnt_o=2.
- Simultaneous lock loss and sw_rst_req_i in one cycle → boot_cnt_o increments by exactly 1, and start_addr_o takes the new value.
- With BOOT_WDT_EN and WDT_CYCLES=8:
  - Kicking every 5 cycles → no reboot.
  - Stopping kicks → reboot 8 cycles after the last kick, wdt_expired_o=1, and the flag stays 1 after re-entering RUN.
- Assert `arst` mid-HOLD → mem_rst_no=0 asynchronously, boot_cnt_o=0, start_addr_o=32'h8000_0000.
